// File: rtl/ddr_fifo_pkg.sv
// rtl/ddr_fifo_pkg.sv - shared DDR TX FIFO constants and Gray/binary helper
// Used by the read-side pointer synchroniser and the write-side full-flag logic.
package ddr_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEFAULT_PTR_R   = 12;
  localparam int GRAY_W_MAX      = 32;

  // Callers zero-extend narrower pointers; leading zeros leave the result unchanged.
  function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
    logic [GRAY_W_MAX-1:0] b;
    b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
    for (int i = GRAY_W_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_ptr_sync_status_if.sv
// rtl/rd_ptr_sync_status_if.sv - pointer/status bundle between FIFO read logic and rd_ptr_sync_status
// slave: the synchroniser/status block; master: the FIFO read-side user.
interface rd_ptr_sync_status_if
  import ddr_fifo_pkg::*;
#(
  parameter int PTR_R = DEFAULT_PTR_R
);

  logic [PTR_R:0] i_wr_ptr_gray;
  logic [PTR_R:0] i_rd_ptr_bin;
  logic [PTR_R:0] o_wr_ptr_gray;
  logic [PTR_R:0] o_wr_ptr_bin;
  logic [PTR_R:0] o_level;
  logic           o_empty;
  logic           o_aempty;
  logic           o_ptr_update;
  logic           o_gray_err;

  modport slave (
    input  i_wr_ptr_gray,
    input  i_rd_ptr_bin,
    output o_wr_ptr_gray,
    output o_wr_ptr_bin,
    output o_level,
    output o_empty,
    output o_aempty,
    output o_ptr_update,
    output o_gray_err
  );

  modport master (
    output i_wr_ptr_gray,
    output i_rd_ptr_bin,
    input  o_wr_ptr_gray,
    input  o_wr_ptr_bin,
    input  o_level,
    input  o_empty,
    input  o_aempty,
    input  o_ptr_update,
    input  o_gray_err
  );

endinterface

// File: rtl/ptr_sync_chain.sv
// rtl/ptr_sync_chain.sv - multi-flop synchroniser for a Gray-coded pointer
// Pure flop chain: nothing may sit between stages or the MTBF analysis breaks.
module ptr_sync_chain #(
  parameter int WIDTH  = 13,
  parameter int STAGES = 2
) (
  input  logic             i_rd_clk,
  input  logic             i_rd_rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      for (int n = 0; n < STAGES; n++) begin
        sync_q[n] <= '0;
      end
    end else begin
      sync_q[0] <= d;
      for (int n = 1; n < STAGES; n++) begin
        sync_q[n] <= sync_q[n-1];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rd_ptr_sync_status.sv
// rtl/rd_ptr_sync_status.sv - write-pointer synchroniser with read-side level/empty/almost-empty status
// Optional sticky Gray-violation checker enabled by RD_PTR_SYNC_GRAY_CHECK_EN.
module rd_ptr_sync_status
  import ddr_fifo_pkg::*;
#(
  parameter int PTR_R         = DEFAULT_PTR_R,
  parameter int SYNC_STAGES   = 2,
  parameter int AEMPTY_THRESH = 4
) (
  input logic                 i_rd_clk,
  input logic                 i_rd_rst,
  rd_ptr_sync_status_if.slave bus
);

  localparam int             W          = PTR_R + 1;
  localparam logic [PTR_R:0] AEMPTY_LVL = W'(AEMPTY_THRESH);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("rd_ptr_sync_status: SYNC_STAGES=%0d outside %0d..%0d",
           SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= (2 ** PTR_R)) begin : g_bad_thresh
    $error("rd_ptr_sync_status: AEMPTY_THRESH=%0d outside 0..2^PTR_R-1", AEMPTY_THRESH);
  end
  if (W > GRAY_W_MAX) begin : g_bad_width
    $error("rd_ptr_sync_status: PTR_R=%0d exceeds gray2bin width", PTR_R);
  end

  logic [PTR_R:0] gray_sync;
  logic [PTR_R:0] gray_prev_q;
  logic [PTR_R:0] wr_bin_q,  wr_bin_d;
  logic [PTR_R:0] level_q,   level_d;
  logic           empty_q,   empty_d;
  logic           aempty_q,  aempty_d;
  logic           ptr_update_q, ptr_update_d;

  ptr_sync_chain #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_chain (
    .i_rd_clk (i_rd_clk),
    .i_rd_rst (i_rd_rst),
    .d        (bus.i_wr_ptr_gray),
    .q        (gray_sync)
  );

  // One combinational level feeds every flag so the status outputs never disagree.
  always_comb begin
    wr_bin_d     = W'(gray2bin(GRAY_W_MAX'(gray_sync)));
    level_d      = wr_bin_d - bus.i_rd_ptr_bin;
    empty_d      = (level_d == '0);
    aempty_d     = (level_d <= AEMPTY_LVL);
    ptr_update_d = (gray_sync != gray_prev_q);
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      gray_prev_q  <= '0;
      wr_bin_q     <= '0;
      level_q      <= '0;
      empty_q      <= 1'b1;
      aempty_q     <= 1'b1;
      ptr_update_q <= 1'b0;
    end else begin
      gray_prev_q  <= gray_sync;
      wr_bin_q     <= wr_bin_d;
      level_q      <= level_d;
      empty_q      <= empty_d;
      aempty_q     <= aempty_d;
      ptr_update_q <= ptr_update_d;
    end
  end

`ifdef RD_PTR_SYNC_GRAY_CHECK_EN
  logic [PTR_R:0] gray_diff;
  logic           gray_err_q, gray_err_d;

  // More than one set bit in the step means the source broke Gray ordering.
  always_comb begin
    gray_diff  = gray_sync ^ gray_prev_q;
    gray_err_d = gray_err_q | (|(gray_diff & (gray_diff - W'(1))));
  end

  always_ff @(posedge i_rd_clk) begin
    if (i_rd_rst) begin
      gray_err_q <= 1'b0;
    end else begin
      gray_err_q <= gray_err_d;
    end
  end

  assign bus.o_gray_err = gray_err_q;
`else
  assign bus.o_gray_err = 1'b0;
`endif

  assign bus.o_wr_ptr_gray = gray_sync;
  assign bus.o_wr_ptr_bin  = wr_bin_q;
  assign bus.o_level       = level_q;
  assign bus.o_empty       = empty_q;
  assign bus.o_aempty      = aempty_q;
  assign bus.o_ptr_update  = ptr_update_q;

endmodule

// File: tb/tb_rd_ptr_sync_status.sv
// tb/tb_rd_ptr_sync_status.sv - scoreboard bench for rd_ptr_sync_status (PTR_R=4, SYNC_STAGES=2, AEMPTY_THRESH=4)
module tb_rd_ptr_sync_status;

  localparam int PTR_R = 4;
`ifdef RD_PTR_SYNC_GRAY_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] gray;
    logic [4:0] bin;
    logic [4:0] level;
    logic       empty;
    logic       aempty;
    logic       upd;
    logic       err;
  } status_t;

  typedef struct {
    int      due;
    status_t st;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rd_ptr_sync_status_if #(.PTR_R(PTR_R)) sif ();

  rd_ptr_sync_status #(
    .PTR_R         (PTR_R),
    .SYNC_STAGES   (2),
    .AEMPTY_THRESH (4)
  ) dut (
    .i_rd_clk (clk),
    .i_rd_rst (rst),
    .bus      (sif)
  );

  exp_t       exp_q[$];
  exp_t       e;
  status_t    obs;
  int         cyc     = 0;
  int         n_cmp   = 0;
  int         n_bad   = 0;
  logic [4:0] cur_bin = '0;

  function automatic logic [4:0] g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic status_t mk(input logic [4:0] gr, input logic [4:0] bn,
                                 input logic [4:0] lv, input logic upd, input logic err);
    status_t s;
    s.gray   = gr;
    s.bin    = bn;
    s.level  = lv;
    s.empty  = (lv == 5'd0);
    s.aempty = (lv <= 5'd4);
    s.upd    = upd;
    s.err    = err;
    return s;
  endfunction

  function status_t observe();
    status_t s;
    s.gray   = sif.o_wr_ptr_gray;
    s.bin    = sif.o_wr_ptr_bin;
    s.level  = sif.o_level;
    s.empty  = sif.o_empty;
    s.aempty = sif.o_aempty;
    s.upd    = sif.o_ptr_update;
    s.err    = sif.o_gray_err;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic expect_at(input int off, input status_t st);
    exp_q.push_back('{due: cyc + off, st: st});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sif.i_wr_ptr_gray = '0;
    sif.i_rd_ptr_bin  = '0;
    cur_bin = '0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    exp_q.delete();
  endtask

  task automatic walk_to(input logic [4:0] target);
    while (cur_bin != target) begin
      cur_bin = cur_bin + 5'd1;
      sif.i_wr_ptr_gray = g(cur_bin);
      tick();
    end
    repeat (4) tick();
  endtask

  task automatic test_reset();
    status_t rst_st;
    rst_st = mk(5'h00, 5'h00, 5'h00, 1'b0, 1'b0);
    rst = 1'b1;
    sif.i_wr_ptr_gray = 5'h1A;
    sif.i_rd_ptr_bin  = 5'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      obs = observe();
      n_cmp++;
      if (obs !== rst_st) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", cyc, obs, rst_st);
      end
    end
    rst = 1'b0;
    expect_at(1, rst_st);
    expect_at(2, mk(5'h1A, 5'h00, 5'h00, 1'b0, 1'b0));
    expect_at(3, mk(5'h1A, 5'h13, 5'h13, 1'b1, EXP_ERR));
    expect_at(4, mk(5'h1A, 5'h13, 5'h13, 1'b0, EXP_ERR));
    repeat (6) begin
      tick();
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        obs = observe();
        n_cmp++;
        if (obs !== e.st) begin
          n_bad++;
          $display("FAIL reset_release cyc=%0d got=%h want=%h", cyc, obs, e.st);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_latency();
    do_reset();
    sif.i_wr_ptr_gray = 5'h01;
    expect_at(1, mk(5'h00, 5'h00, 5'h00, 1'b0, 1'b0));
    expect_at(2, mk(5'h01, 5'h00, 5'h00, 1'b0, 1'b0));
    expect_at(3, mk(5'h01, 5'h01, 5'h01, 1'b1, 1'b0));
    expect_at(4, mk(5'h01, 5'h01, 5'h01, 1'b0, 1'b0));
    repeat (6) begin
      tick();
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        obs = observe();
        n_cmp++;
        if (obs !== e.st) begin
          n_bad++;
          $display("FAIL latency cyc=%0d got=%h want=%h", cyc, obs, e.st);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL latency_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_threshold_full();
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      cur_bin = 5'(k);
      sif.i_wr_ptr_gray = g(cur_bin);
      expect_at(3, mk(g(cur_bin), cur_bin, cur_bin, 1'b1, 1'b0));
      expect_at(4, mk(g(cur_bin), cur_bin, cur_bin, 1'b0, 1'b0));
      repeat (4) begin
        tick();
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          obs = observe();
          n_cmp++;
          if (obs !== e.st) begin
            n_bad++;
            $display("FAIL threshold_full k=%0d cyc=%0d got=%h want=%h", k, cyc, obs, e.st);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL threshold_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wrap();
    logic [4:0] steps [3];
    steps[0] = 5'h1F;
    steps[1] = 5'h00;
    steps[2] = 5'h01;
    do_reset();
    walk_to(5'h1E);
    sif.i_rd_ptr_bin = 5'h1E;
    expect_at(1, mk(g(5'h1E), 5'h1E, 5'h00, 1'b0, 1'b0));
    for (int s = 0; s <= 3; s++) begin
      if (s > 0) begin
        cur_bin = steps[s-1];
        sif.i_wr_ptr_gray = g(cur_bin);
        expect_at(3, mk(g(cur_bin), cur_bin, 5'(s), 1'b1, 1'b0));
      end
      repeat (4) begin
        tick();
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
          e = exp_q.pop_front();
          obs = observe();
          n_cmp++;
          if (obs !== e.st) begin
            n_bad++;
            $display("FAIL wrap step=%0d cyc=%0d got=%h want=%h", s, cyc, obs, e.st);
          end
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    walk_to(5'd6);
    sif.i_rd_ptr_bin = 5'd2;
    repeat (2) tick();
    cur_bin = 5'd7;
    sif.i_wr_ptr_gray = g(cur_bin);
    expect_at(2, mk(g(5'd7), 5'd6, 5'd4, 1'b0, 1'b0));
    expect_at(3, mk(g(5'd7), 5'd7, 5'd4, 1'b1, 1'b0));
    expect_at(4, mk(g(5'd7), 5'd7, 5'd4, 1'b0, 1'b0));
    for (int i = 1; i <= 6; i++) begin
      tick();
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        obs = observe();
        n_cmp++;
        if (obs !== e.st) begin
          n_bad++;
          $display("FAIL simultaneous cyc=%0d got=%h want=%h", cyc, obs, e.st);
        end
      end
      if (i == 2) sif.i_rd_ptr_bin = 5'd3;
      if (i == 4) begin
        sif.i_rd_ptr_bin = 5'd7;
        expect_at(1, mk(g(5'd7), 5'd7, 5'd0, 1'b0, 1'b0));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL simultaneous_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid_update();
    status_t rst_st;
    rst_st = mk(5'h00, 5'h00, 5'h00, 1'b0, 1'b0);
    do_reset();
    sif.i_wr_ptr_gray = 5'h01;
    tick();
    sif.i_wr_ptr_gray = 5'h00;
    rst = 1'b1;
    expect_at(1, rst_st);
    tick();
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      obs = observe();
      n_cmp++;
      if (obs !== e.st) begin
        n_bad++;
        $display("FAIL reset_mid_hold cyc=%0d got=%h want=%h", cyc, obs, e.st);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) expect_at(i, rst_st);
    repeat (5) begin
      tick();
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        obs = observe();
        n_cmp++;
        if (obs !== e.st) begin
          n_bad++;
          $display("FAIL reset_mid_after cyc=%0d got=%h want=%h", cyc, obs, e.st);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL reset_mid_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_gray_check();
    do_reset();
    sif.i_wr_ptr_gray = 5'h03;
    expect_at(2, mk(5'h03, 5'h00, 5'h00, 1'b0, 1'b0));
    expect_at(3, mk(5'h03, 5'h02, 5'h02, 1'b1, EXP_ERR));
    expect_at(6, mk(5'h03, 5'h02, 5'h02, 1'b0, EXP_ERR));
    for (int i = 1; i <= 14; i++) begin
      tick();
      while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        obs = observe();
        n_cmp++;
        if (obs !== e.st) begin
          n_bad++;
          $display("FAIL gray_check cyc=%0d got=%h want=%h", cyc, obs, e.st);
        end
      end
      if (i == 7) begin
        sif.i_wr_ptr_gray = 5'h02;
        expect_at(3, mk(5'h02, 5'h03, 5'h03, 1'b1, EXP_ERR));
        expect_at(6, mk(5'h02, 5'h03, 5'h03, 1'b0, EXP_ERR));
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL gray_check_drain pending=%0d want=0", exp_q.size());
      exp_q.delete();
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (sif.o_gray_err !== 1'b0) begin
      n_bad++;
      $display("FAIL gray_err_cleared got=%b want=0", sif.o_gray_err);
    end
    rst = 1'b0;
  endtask

  initial begin
    sif.i_wr_ptr_gray = '0;
    sif.i_rd_ptr_bin  = '0;
    test_reset();
    test_latency();
    test_threshold_full();
    test_wrap();
    test_simultaneous();
    test_reset_mid_update();
    test_gray_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rd_ptr_sync_status.md
Name: rd_ptr_sync_status

Overview:
- Parametrised successor to the two-flop write-pointer synchroniser on the DDR TX FIFO read side.
- Carries a Gray-coded write pointer into the read clock domain through a configurable-depth flop chain, then converts it to binary.
- Computes read-side fill level, empty and almost-empty locally, so FIFO read logic needs no separate status block.

Parameters:
- PTR_R, 12, MSB index of pointer; pointers are PTR_R+1 bits (extra wrap bit), FIFO depth 2^PTR_R.
- SYNC_STAGES, 2, synchroniser flop count; legal 2..4, elaboration error otherwise.
- AEMPTY_THRESH, 4, o_aempty asserts when level <= this value; legal 0..2^PTR_R-1.

Ports:
- i_rd_clk  in  1  read-domain clock, only clock in block.
- i_rd_rst  in  1  synchronous, active-high reset.
- i_wr_ptr_gray  in  PTR_R+1  Gray write pointer from write domain; asynchronous to i_rd_clk.
- i_rd_ptr_bin  in  PTR_R+1  local binary read pointer, i_rd_clk domain.
- o_wr_ptr_gray  out  PTR_R+1  synchronised Gray write pointer (last chain stage).
- o_wr_ptr_bin  out  PTR_R+1  registered binary of o_wr_ptr_gray.
- o_level  out  PTR_R+1  registered occupancy, 0..2^PTR_R.
- o_empty  out  1  registered, level == 0.
- o_aempty  out  1  registered, level <= AEMPTY_THRESH.
- o_ptr_update  out  1  one-cycle pulse; synchronised pointer changed.
- o_gray_err  out  1  sticky Gray-violation flag (see Optional Feature).

Behaviour:
- Reset (i_rd_rst high at posedge): all chain stages, o_wr_ptr_gray, o_wr_ptr_bin, o_level cleared to 0. o_empty=1, o_aempty=1, o_ptr_update=0, o_gray_err=0. Reset overrides all other activity on that edge, including mid-update.
- Sync chain: stage[0] <= i_wr_ptr_gray; stage[n] <= stage[n-1]. o_wr_ptr_gray = stage[SYNC_STAGES-1].
  - Latency from a stable input change to o_wr_ptr_gray: SYNC_STAGES edges.
  - No logic between chain stages.
- Status register: one edge after o_wr_ptr_gray updates:
  - o_wr_ptr_bin = gray2bin(o_wr_ptr_gray), where bin[PTR_R] = g[PTR_R] and bin[i] = bin[i+1] ^ g[i].
  - o_level = (gray2bin(o_wr_ptr_gray) - i_rd_ptr_bin) mod 2^(PTR_R+1).
  - o_empty and o_aempty are derived from the same combinational level value, so all status outputs stay mutually consistent every cycle.
  - Total write-to-status latency: SYNC_STAGES+1 cycles.
- i_rd_ptr_bin is sampled every cycle with zero synchronisation. A read-pointer change is reflected in o_level one cycle later.
- Simultaneous write-pointer update and read-pointer change: both are used in the same level computation. No priority and no lost update.
- Wrap-around: level arithmetic is modulo 2^(PTR_R+1). Example for PTR_R=4: wr=0x01, rd=0x1F gives level 2.
- Full FIFO: level=2^PTR_R is legal. A computed level above 2^PTR_R indicates a FIFO-level bug and is reported in o_level unclamped.
- o_ptr_update: high for exactly one cycle whenever o_wr_ptr_gray differs from its value on the previous cycle. It is aligned with the cycle where o_wr_ptr_bin shows the new value. It is low during reset and on the first cycle after reset.
- Input changes must be Gray (at most 1 bit per write-clock edge). The block does not filter multi-bit changes.

Optional Feature:
- Macro: RD_PTR_SYNC_GRAY_CHECK_EN.
- Defined: a registered comparator checks consecutive o_wr_ptr_gray values. If they differ in more than one bit, o_gray_err sets on the next edge and stays set until i_rd_rst.
- Undefined: comparator logic is absent and o_gray_err is tied to 0. The port list is identical in both builds.

Decomposition:
- Shared package ddr_fifo_pkg holds:
  - constants SYNC_STAGES_MIN=2 and SYNC_STAGES_MAX=4;
  - default PTR_R=12;
  - function gray2bin, which is reused by the write-side full-flag logic.
- One sub-module: ptr_sync_chain (params WIDTH, STAGES; ports i_rd_clk, i_rd_rst, d, q). It is the flop chain only and carries the ASYNC_REG/synchroniser attributes.
- Conversion, level, flags and the optional checker stay in rd_ptr_sync_status.

Test Plan:
- All tests use PTR_R=4, SYNC_STAGES=2, AEMPTY_THRESH=4.
- Reset: hold i_rd_rst 3 cycles with input gray=0x1A -> all outputs 0 except o_empty=1, o_aempty=1; after release, status shows bin=0x13 on cycle 3.
- Latency: with rd=0, step i_wr_ptr_gray 0x00->0x01 at cycle 0 -> o_wr_ptr_gray=0x01 at cycle 2; o_wr_ptr_bin=1, o_level=1, o_empty=0, o_aempty=1, o_ptr_update=1 at cycle 3 only.
- Threshold and full: advance the write Gray count to bin 5 then 16 with rd=0 -> o_aempty drops when level=5; level=16 gives o_empty=0.
- Wrap: wr bin 0x1F->0x00->0x01 (Gray 0x10, 0x00, 0x01) with rd=0x1E -> levels 1, 2, 3.
- Simultaneous: wr bin 6->7 and rd 2->3 arrive at the status stage on the same edge -> level stays 4, o_ptr_update=1.
- Gray check (macro defined): drive 0x00->0x03 -> o_gray_err=1 three cycles later and sticky until reset. Same stimulus with macro undefined -> o_gray_err=0.
